fetch_pc_predictor: RTL and testbench
=====================================

// Module: fetch_pc_predictor
// PURPOSE
//  Instruction-fetch front end feeding the IF/ID pipeline register: owns the PC register and a table of
//  2-bit saturating branch predictors. Chooses the next PC each cycle from four sources: sequential,
//  ID-stage predicted-taken target, EX-stage mispredict correction, or a stall hold.
//  Drives the imem address and pc into IF/ID, and the flush strobes for IF/ID and ID/EX.
// PARAMETERS
//  XLEN          32      datapath / PC width
//  BHT_IDX_BITS  4       predictor index width; 2**BHT_IDX_BITS entries, index = pc[BHT_IDX_BITS+1:2]
//  RESET_PC      32'h0   PC value after reset
//  CNT_INIT      2'b01   counter reset state (weakly not-taken)
// PORTS
//  clk_i            in   1     clock, rising edge
//  rst_i            in   1     asynchronous, active-high reset
//  Stall_i          in   1     hazard-unit stall; hold PC
//  id_branch_i      in   1     ID holds a conditional branch
//  id_pc_i          in   XLEN  PC of the ID instruction
//  id_target_i      in   XLEN  branch target computed in ID
//  ex_branch_i      in   1     EX holds a resolved conditional branch
//  ex_pc_i          in   XLEN  PC of the EX branch
//  ex_target_i      in   XLEN  branch target of the EX branch
//  ex_taken_i       in   1     actual outcome
//  ex_pred_i        in   1     prediction carried down with that branch
//  pc_o             out  XLEN  current fetch PC (imem address, IF/ID pc_i)
//  predict_taken_o  out  1     ID branch predicted taken (carried down the pipe)
//  flush_ifid_o     out  1     flush IF/ID
//  flush_idex_o     out  1     flush ID/EX
//  mispredict_cnt_o out  32    saturating mispredict count (perf)
// BEHAVIOUR
//  Reset (async, any time incl. mid-redirect): pc_o=RESET_PC, every counter=CNT_INIT,
//   mispredict_cnt_o=0; combinational outputs follow from that state.
//  Lookup (combinational): predict_taken_o = id_branch_i & bht[idx(id_pc_i)][1].
//  Mispredict: mispredict = ex_branch_i & (ex_taken_i != ex_pred_i).
//   Correction PC = ex_taken_i ? ex_target_i : ex_pc_i+4.
//  Next-PC priority, registered on clk edge:
//   1) mispredict   -> correction PC (overrides Stall_i)
//   2) Stall_i      -> hold pc_o
//   3) predict_taken_o -> id_target_i
//   4) otherwise    -> pc_o+4
//  All PC adds are modulo 2**XLEN (wrap 32'hFFFFFFFC -> 0).
//  flush_ifid_o = mispredict | (predict_taken_o & ~Stall_i).
//  flush_idex_o = mispredict.
//  Latency: one cycle from select to pc_o; a predicted-taken branch costs 1 bubble;
//   a mispredict costs 2 bubbles.
//  Update: when ex_branch_i, counter at idx(ex_pc_i) steps +1 if taken, -1 if not.
//   Counter saturates at 2'b11 / 2'b00. Update is independent of Stall_i.
//  Same-cycle update and lookup of one index: lookup sees the pre-update value
//   (write takes effect next edge).
//  mispredict_cnt_o increments on each mispredict and saturates at 32'hFFFFFFFF.
// STRUCTURE
//  Shared package fetch_pkg: counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
//   PC_STEP=4; default RESET_PC.
//  One sub-module, branch_history_table:
//   - array of 2-bit counters, async reset
//   - one combinational read port, one synchronous update port
//  PC register, next-PC mux and perf counter stay in this module.
// TESTING
//  1) Reset, no branches, 4 cycles -> pc_o 0,4,8,12; flush strobes 0; predict_taken_o 0.
//  2) id_branch_i=1 at id_pc_i=0x20, counter=WNT -> predict_taken_o=0, next PC sequential.
//     Same case with counter=WT and id_target_i=0x100 -> pc_o=0x100 next cycle, flush_ifid_o=1.
//  3) EX branch at 0x20, taken=1, pred=0, ex_target_i=0x80, with Stall_i=1 -> pc_o=0x80 next;
//     flush_idex_o=1; counter 0x20 WNT->WT; mispredict_cnt_o=1.
//  4) EX branch at 0x40, taken=0, pred=1 -> pc_o=0x44; both flushes=1.
//     Three further not-taken resolutions -> counter ST->SNT, holds at SNT.
//  5) Same cycle: ex update and id lookup of index 3, counter WNT, ex taken
//     -> predict_taken_o=0 this cycle, 1 the next.
//  6) Assert rst_i mid-redirect; pc_o=32'hFFFFFFFC with no branch
//     -> pc_o=RESET_PC immediately, counters=CNT_INIT; after release, 0xFFFFFFFC+4 wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: predictor counter encodings, PC step, default reset PC.
// The saturating step helper is used by the predictor table's update port.
package fetch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != ST) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != SNT) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// 2-bit saturating predictor array; combinational read, update lands on the next edge.
// No backpressure: an update is accepted on every cycle that upd_vld_i is high.
module branch_history_table
    import fetch_pkg::*;
#(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [1:0]          rd_cnt_o,
    input  logic                upd_vld_i,
    input  logic [IDX_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] cnt_q [ENTRIES];

    // Read returns the pre-update value when the same index is written this cycle.
    assign rd_cnt_o = cnt_q[rd_idx_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd_vld_i) begin
            cnt_q[upd_idx_i] <= sat_step(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch PC register with branch prediction; new PC appears one cycle after selection.
// Stall_i holds the PC unless an EX mispredict forces a redirect in the same cycle.
module fetch_pc_predictor
    import fetch_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               BHT_IDX_BITS = 4,
    parameter logic [XLEN-1:0]  RESET_PC     = XLEN'(DEFAULT_RESET_PC),
    parameter logic [1:0]       CNT_INIT     = WNT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            Stall_i,
    input  logic            id_branch_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_target_i,
    input  logic            ex_branch_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_taken_i,
    input  logic            ex_pred_i,
    output logic [XLEN-1:0] pc_o,
    output logic            predict_taken_o,
    output logic            flush_ifid_o,
    output logic            flush_idex_o,
    output logic [31:0]     mispredict_cnt_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     mcnt_q, mcnt_d;
    logic [1:0]      id_cnt;
    logic            mispredict;
    logic [XLEN-1:0] correction_pc;
    logic            unused_id_pc;

    assign unused_id_pc = ^{id_pc_i[XLEN-1:BHT_IDX_BITS+2], id_pc_i[1:0]};

    branch_history_table #(
        .IDX_BITS (BHT_IDX_BITS),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (id_pc_i[BHT_IDX_BITS+1:2]),
        .rd_cnt_o    (id_cnt),
        .upd_vld_i   (ex_branch_i),
        .upd_idx_i   (ex_pc_i[BHT_IDX_BITS+1:2]),
        .upd_taken_i (ex_taken_i)
    );

    assign predict_taken_o = id_branch_i & id_cnt[1];
    assign mispredict      = ex_branch_i & (ex_taken_i != ex_pred_i);
    assign correction_pc   = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(PC_STEP);

    assign flush_ifid_o = mispredict | (predict_taken_o & ~Stall_i);
    assign flush_idex_o = mispredict;

    // Mispredict correction outranks a stall: the stalled instruction is on the wrong path.
    always_comb begin
        pc_d = pc_q + XLEN'(PC_STEP);
        if (mispredict) begin
            pc_d = correction_pc;
        end else if (Stall_i) begin
            pc_d = pc_q;
        end else if (predict_taken_o) begin
            pc_d = id_target_i;
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (mispredict && mcnt_q != 32'hFFFF_FFFF) begin
            mcnt_d = mcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            mcnt_q <= '0;
        end else begin
            pc_q   <= pc_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign pc_o             = pc_q;
    assign mispredict_cnt_o = mcnt_q;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: reference model compared every negedge plus literal checks.
module tb_fetch_pc_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        Stall_i = 1'b0;
    logic        id_branch_i = 1'b0;
    logic [31:0] id_pc_i = '0;
    logic [31:0] id_target_i = '0;
    logic        ex_branch_i = 1'b0;
    logic [31:0] ex_pc_i = '0;
    logic [31:0] ex_target_i = '0;
    logic        ex_taken_i = 1'b0;
    logic        ex_pred_i = 1'b0;
    logic [31:0] pc_o;
    logic        predict_taken_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic [31:0] mispredict_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fetch_pc_predictor dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .Stall_i          (Stall_i),
        .id_branch_i      (id_branch_i),
        .id_pc_i          (id_pc_i),
        .id_target_i      (id_target_i),
        .ex_branch_i      (ex_branch_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_taken_i       (ex_taken_i),
        .ex_pred_i        (ex_pred_i),
        .pc_o             (pc_o),
        .predict_taken_o  (predict_taken_o),
        .flush_ifid_o     (flush_ifid_o),
        .flush_idex_o     (flush_idex_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    // Reference model: counters as plain integers 0..3, PC as 64-bit arithmetic mod 2**32.
    longint unsigned m_pc;
    longint unsigned m_mcnt;
    int              m_bht [16];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_mispred();
        return ex_branch_i && (ex_taken_i != ex_pred_i);
    endfunction

    function automatic bit m_pred();
        return id_branch_i && (m_bht[idx_of(id_pc_i)] >= 2);
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pc   = 0;
            m_mcnt = 0;
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
        end else begin
            if (m_mispred())
                m_pc = ex_taken_i ? longint'(ex_target_i) : (longint'(ex_pc_i) + 4) % 64'h1_0000_0000;
            else if (Stall_i)
                m_pc = m_pc;
            else if (m_pred())
                m_pc = longint'(id_target_i);
            else
                m_pc = (m_pc + 4) % 64'h1_0000_0000;
            if (m_mispred() && m_mcnt < 64'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
            if (ex_branch_i) begin
                if (ex_taken_i) m_bht[idx_of(ex_pc_i)] = (m_bht[idx_of(ex_pc_i)] == 3) ? 3 : m_bht[idx_of(ex_pc_i)] + 1;
                else            m_bht[idx_of(ex_pc_i)] = (m_bht[idx_of(ex_pc_i)] == 0) ? 0 : m_bht[idx_of(ex_pc_i)] - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        chk("model_pc", pc_o, 32'(m_pc));
        chk("model_pred", {31'd0, predict_taken_o}, {31'd0, m_pred()});
        chk("model_flush_ifid", {31'd0, flush_ifid_o}, {31'd0, m_mispred() || (m_pred() && !Stall_i)});
        chk("model_flush_idex", {31'd0, flush_idex_o}, {31'd0, m_mispred()});
        chk("model_mcnt", mispredict_cnt_o, 32'(m_mcnt));
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // 1) reset and sequential fetch
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pred", {31'd0, predict_taken_o}, 32'd0);
        chk("rst_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd0);
        chk("rst_mcnt", mispredict_cnt_o, 32'd0);
        cyc();
        rst_i = 1'b0;
        chk("seq_pc0", pc_o, 32'h0);
        cyc(); chk("seq_pc4", pc_o, 32'h4);
        cyc(); chk("seq_pc8", pc_o, 32'h8);
        cyc(); chk("seq_pc12", pc_o, 32'hC);

        // 2a) branch at 0x20 with weakly-not-taken counter
        id_branch_i = 1'b1; id_pc_i = 32'h20; id_target_i = 32'h100;
        #1;
        chk("wnt_pred", {31'd0, predict_taken_o}, 32'd0);
        cyc(); chk("wnt_seq_pc", pc_o, 32'h10);

        // 3) mispredict under stall
        id_branch_i = 1'b0;
        Stall_i = 1'b1; ex_branch_i = 1'b1; ex_pc_i = 32'h20; ex_taken_i = 1'b1; ex_pred_i = 1'b0; ex_target_i = 32'h80;
        #1;
        chk("mp_flush_idex", {31'd0, flush_idex_o}, 32'd1);
        cyc();
        chk("mp_pc", pc_o, 32'h80);
        chk("mp_cnt1", mispredict_cnt_o, 32'd1);

        // 2b) counter now WT: predicted taken redirect
        ex_branch_i = 1'b0; Stall_i = 1'b0;
        id_branch_i = 1'b1; id_pc_i = 32'h20; id_target_i = 32'h100;
        #1;
        chk("wt_pred", {31'd0, predict_taken_o}, 32'd1);
        chk("wt_flush_ifid", {31'd0, flush_ifid_o}, 32'd1);
        chk("wt_flush_idex", {31'd0, flush_idex_o}, 32'd0);
        cyc(); chk("wt_target_pc", pc_o, 32'h100);

        // 4) counter at 0x40 driven to ST, then mispredicted not-taken and walked down
        id_branch_i = 1'b0;
        ex_branch_i = 1'b1; ex_pc_i = 32'h40; ex_taken_i = 1'b1; ex_pred_i = 1'b1; ex_target_i = 32'h300;
        cyc(); cyc();
        ex_taken_i = 1'b0; ex_pred_i = 1'b1;
        #1;
        chk("nt_flushes", {30'd0, flush_ifid_o, flush_idex_o}, 32'd3);
        cyc();
        chk("nt_pc", pc_o, 32'h44);
        chk("nt_cnt2", mispredict_cnt_o, 32'd2);
        ex_pred_i = 1'b0;
        id_branch_i = 1'b1; id_pc_i = 32'h40;
        #1; chk("dn_wt_pred", {31'd0, predict_taken_o}, 32'd1);
        cyc(); chk("dn_wnt_pred", {31'd0, predict_taken_o}, 32'd0);
        cyc(); cyc();
        ex_branch_i = 1'b0;
        #1; chk("dn_snt_pred", {31'd0, predict_taken_o}, 32'd0);
        cyc();

        // 5) same-cycle update and lookup of index 3
        id_branch_i = 1'b1; id_pc_i = 32'h0C; id_target_i = 32'h180;
        ex_branch_i = 1'b1; ex_pc_i = 32'h0C; ex_taken_i = 1'b1; ex_pred_i = 1'b1;
        #1; chk("same_pre", {31'd0, predict_taken_o}, 32'd0);
        cyc();
        ex_branch_i = 1'b0;
        #1; chk("same_post", {31'd0, predict_taken_o}, 32'd1);
        id_branch_i = 1'b0;
        cyc();

        // 6) wrap at top of address space, then reset mid-redirect
        ex_branch_i = 1'b1; ex_pc_i = 32'h60; ex_taken_i = 1'b1; ex_pred_i = 1'b0; ex_target_i = 32'hFFFF_FFFC;
        cyc();
        ex_branch_i = 1'b0;
        chk("wrap_top", pc_o, 32'hFFFF_FFFC);
        chk("wrap_cnt3", mispredict_cnt_o, 32'd3);
        cyc(); chk("wrap_zero", pc_o, 32'h0);
        ex_branch_i = 1'b1;
        cyc();
        chk("top_again", pc_o, 32'hFFFF_FFFC);
        ex_target_i = 32'h200;
        id_branch_i = 1'b1; id_pc_i = 32'h20;
        #1;
        chk("pre_rst_pred", {31'd0, predict_taken_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_pred", {31'd0, predict_taken_o}, 32'd0);
        chk("mid_rst_mcnt", mispredict_cnt_o, 32'd0);
        ex_branch_i = 1'b0; id_branch_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        chk("post_rst_pc", pc_o, 32'h0);
        cyc(); chk("post_rst_seq", pc_o, 32'h4);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
